// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default sizing for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MEM_LAT      = 1;
  localparam int DEF_MAX_D_STREAK = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Down-counter that holds the arbiter in WAIT until the memory read data is due.
// Loaded with MEM_LAT-1 in ISSUE; o_done marks the WAIT cycle in which read data is valid.
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  logic [1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 2'(MEM_LAT - 1);
    end else if (i_dec && (r_cnt != 2'd0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_done = (r_cnt == 2'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port memory between instruction fetch and data accesses.
// One transaction in flight; ACK arrives 2+MEM_LAT cycles after the request is granted in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [31:0]       IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              M_EN,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              BUSY
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_own_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [SW-1:0]     r_streak;
  logic              w_grant_d;
  logic              w_grant_f;
  logic              w_capture;
  logic              w_lat_done;
  logic              w_unused;

  // Upper fetch-address bits are deliberately ignored.
  assign w_unused = ^(IF_ADDR >> ADDR_W);

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (r_state == ST_ISSUE),
    .i_dec  (r_state == ST_WAIT),
    .o_done (w_lat_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_f   = 1'b0;
    w_capture   = 1'b0;
    M_EN        = 1'b0;
    M_WE        = 1'b0;
    IF_ACK      = 1'b0;
    D_ACK       = 1'b0;
    BUSY        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        BUSY      = 1'b0;
        w_grant_d = D_REQ && (!IF_REQ || (r_streak < STREAK_MAX));
        w_grant_f = IF_REQ && !w_grant_d;
        if (w_grant_d || w_grant_f) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        M_EN        = 1'b1;
        M_WE        = r_own_d && r_we;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_lat_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        IF_ACK      = !r_own_d;
        D_ACK       = r_own_d;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The streak only counts data grants made while fetch is actually waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_own_d    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_streak   <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (!IF_REQ) begin
          r_streak <= '0;
        end else if (w_grant_d) begin
          r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + SW'(1);
        end else begin
          r_streak <= '0;
        end
        if (w_grant_d) begin
          r_own_d <= 1'b1;
          r_we    <= D_WE;
          r_addr  <= D_ADDR;
          r_wdata <= D_WDATA;
        end else if (w_grant_f) begin
          r_own_d <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= IF_ADDR[ADDR_W-1:0];
        end
      end
      if (w_capture) begin
        if (!r_own_d) begin
          r_if_rdata <= M_RDATA;
        end else if (!r_we) begin
          r_d_rdata <= M_RDATA;
        end
      end
    end
  end

  assign M_ADDR   = r_addr;
  assign M_WDATA  = r_wdata;
  assign IF_RDATA = r_if_rdata;
  assign D_RDATA  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run against a cycle-arithmetic reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, d_req, d_we;
  logic [31:0] if_addr, d_wdata;
  logic [15:0] d_addr;

  logic        if_ack1, d_ack1, m_en1, m_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, m_wdata1, m_rdata1;
  logic [15:0] m_addr1;
  logic        if_ack3, d_ack3, m_en3, m_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, m_wdata3, m_rdata3;
  logic [15:0] m_addr3;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT1), .MAX_D_STREAK(MAXS)) dut1 (
    .CLK(clk), .RST(rst), .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack1),
    .IF_RDATA(if_rdata1), .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_ACK(d_ack1), .D_RDATA(d_rdata1), .M_EN(m_en1), .M_WE(m_we1), .M_ADDR(m_addr1),
    .M_WDATA(m_wdata1), .M_RDATA(m_rdata1), .BUSY(busy1));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT3), .MAX_D_STREAK(MAXS)) dut3 (
    .CLK(clk), .RST(rst), .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack3),
    .IF_RDATA(if_rdata3), .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_ACK(d_ack3), .D_RDATA(d_rdata3), .M_EN(m_en3), .M_WE(m_we3), .M_ADDR(m_addr3),
    .M_WDATA(m_wdata3), .M_RDATA(m_rdata3), .BUSY(busy3));

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a, ~a};
  endfunction

  // Memory models: read data valid exactly LAT cycles after M_EN, junk otherwise.
  logic [3:0]  pv1 = '0, pv3 = '0;
  logic [31:0] pd1 [4];
  logic [31:0] pd3 [4];
  logic [31:0] junk = 32'h0BAD_F00D;
  always @(posedge clk) begin
    junk   <= $urandom;
    pv1    <= {pv1[2:0], m_en1 && !m_we1};
    pv3    <= {pv3[2:0], m_en3 && !m_we3};
    pd1[0] <= mem_val(m_addr1);
    pd3[0] <= mem_val(m_addr3);
    for (int k = 1; k < 4; k++) begin
      pd1[k] <= pd1[k-1];
      pd3[k] <= pd3[k-1];
    end
  end
  assign m_rdata1 = pv1[LAT1-1] ? pd1[LAT1-1] : junk;
  assign m_rdata3 = pv3[LAT3-1] ? pd3[LAT3-1] : junk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one transaction from IDLE; called and returns at posedge+1.
  task automatic txn(input int sel, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int drop_c, input int ncyc,
                     output int en_c, output int ack_c, output int en_n, output int ack_n,
                     output int wrong_n, output int we_n, output logic [15:0] addr_at,
                     output logic [31:0] wdata_at);
    logic en, wev, ack_mine, ack_other;
    en_c = -1; ack_c = -1; en_n = 0; ack_n = 0; wrong_n = 0; we_n = 0;
    addr_at = '0; wdata_at = '0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr[15:0]; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      en        = (sel != 0) ? m_en3 : m_en1;
      wev       = (sel != 0) ? m_we3 : m_we1;
      ack_mine  = is_d ? ((sel != 0) ? d_ack3 : d_ack1) : ((sel != 0) ? if_ack3 : if_ack1);
      ack_other = is_d ? ((sel != 0) ? if_ack3 : if_ack1) : ((sel != 0) ? d_ack3 : d_ack1);
      if (wev) we_n++;
      if (en) begin
        en_n++;
        if (en_c < 0) begin
          en_c     = c;
          addr_at  = (sel != 0) ? m_addr3 : m_addr1;
          wdata_at = (sel != 0) ? m_wdata3 : m_wdata1;
        end
      end
      if (ack_other) wrong_n++;
      if (ack_mine) begin
        ack_n++;
        if (ack_c < 0) ack_c = c;
      end
      if (ack_mine || c == drop_c) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] exp_maddr;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [5];
    int          en_c, ack_c, en_n, ack_n, wrong_n, we_n;
    logic [15:0] addr_at;
    logic [31:0] wdata_at;
    logic [5:0]  ord;
    int          nack, last_ack;
    // reference-model state
    int          free_at, en_at, ack_at, streak;
    bit          own_d, own_we, f_pend, d_pend, f_ackd, d_ackd, exp_en, exp_ack;
    logic [15:0] own_addr;
    logic [31:0] own_wdata, e_if, e_d;

    vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          16'h0010, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,          16'h0042, 32'hDEADBEEF, 32'h0042FFBD};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0042, 32'h12345678,   16'h0042, 32'hDEADBEEF, 32'h0042FFBD};
    vt[3] = '{1'b0, 1'b0, 32'hABCD_1234, 32'h0,          16'h1234, 32'h1234EDCB, 32'h0042FFBD};
    vt[4] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0,          16'hFFFF, 32'h1234EDCB, 32'hFFFF0000};

    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl1", {if_ack1, d_ack1, m_en1, m_we1, busy1}, 5'b0);
    chk("reset_data1", {if_rdata1, d_rdata1}, 64'h0);
    chk("reset_mem1", {m_addr1, m_wdata1}, 48'h0);
    chk("reset_ctrl3", {if_ack3, d_ack3, m_en3, m_we3, busy3}, 5'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed single transactions, LAT=1.
    for (int i = 0; i < 5; i++) begin
      txn(0, vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, -1, 7,
          en_c, ack_c, en_n, ack_n, wrong_n, we_n, addr_at, wdata_at);
      chk($sformatf("v%0d_en_cycle", i), en_c, 1);
      chk($sformatf("v%0d_ack_cycle", i), ack_c, 3);
      chk($sformatf("v%0d_en_count", i), en_n, 1);
      chk($sformatf("v%0d_ack_count", i), ack_n, 1);
      chk($sformatf("v%0d_wrong_ack", i), wrong_n, 0);
      chk($sformatf("v%0d_we_count", i), we_n, (vt[i].is_d && vt[i].we) ? 1 : 0);
      chk($sformatf("v%0d_m_addr", i), addr_at, vt[i].exp_maddr);
      if (vt[i].is_d && vt[i].we) chk($sformatf("v%0d_m_wdata", i), wdata_at, vt[i].wdata);
      chk($sformatf("v%0d_if_rdata", i), if_rdata1, vt[i].exp_if);
      chk($sformatf("v%0d_d_rdata", i), d_rdata1, vt[i].exp_d);
    end

    // Reset while in WAIT: abandoned, no ACK, registers cleared.
    if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (if_ack1 || d_ack1) nack++;
      chk($sformatf("rstwait_outs_c%0d", c), {m_en1, m_we1, busy1, m_addr1, m_wdata1}, 51'h0);
      chk($sformatf("rstwait_rdata_c%0d", c), {if_rdata1, d_rdata1}, 64'h0);
    end
    chk("rstwait_no_ack", nack, 0);
    @(posedge clk); #1 rst = 1'b0;
    txn(0, 1'b0, 1'b0, 32'h20, 32'h0, -1, 7, en_c, ack_c, en_n, ack_n, wrong_n, we_n, addr_at, wdata_at);
    chk("after_rst_en_cycle", en_c, 1);
    chk("after_rst_ack_cycle", ack_c, 3);
    chk("after_rst_if_rdata", if_rdata1, 32'h0020FFDF);

    // Both requesters held continuously: D,D,F,D,D,F.
    do_reset();
    if_addr = 32'h100; d_addr = 16'h200; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
    ord = '0; nack = 0; last_ack = -1;
    for (int c = 0; c < 40 && nack < 6; c++) begin
      @(negedge clk);
      if (d_ack1 || if_ack1) begin
        ord = {ord[4:0], d_ack1};
        nack++;
        last_ack = c;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb_ack_count", nack, 6);
    chk("arb_order_DDFDDF", ord, 6'b110110);
    chk("arb_last_ack_cycle", last_ack, 23);
    @(posedge clk); #1;

    // MEM_LAT=3 load.
    do_reset();
    txn(1, 1'b1, 1'b0, 32'h77, 32'h0, -1, 10, en_c, ack_c, en_n, ack_n, wrong_n, we_n, addr_at, wdata_at);
    chk("lat3_en_cycle", en_c, 1);
    chk("lat3_ack_cycle", ack_c, 5);
    chk("lat3_en_count", en_n, 1);
    chk("lat3_d_rdata", d_rdata3, 32'h0077FF88);

    // D_REQ dropped during ISSUE.
    do_reset();
    txn(0, 1'b1, 1'b0, 32'h42, 32'h0, 1, 8, en_c, ack_c, en_n, ack_n, wrong_n, we_n, addr_at, wdata_at);
    chk("drop_ack_cycle", ack_c, 3);
    chk("drop_ack_count", ack_n, 1);
    chk("drop_en_count", en_n, 1);
    chk("drop_d_rdata", d_rdata1, 32'h0042FFBD);

    // Randomized traffic against the reference model.
    do_reset();
    free_at = 0; en_at = -1; ack_at = -1; streak = 0;
    own_d = 1'b0; own_we = 1'b0; own_addr = '0; own_wdata = '0; e_if = '0; e_d = '0;
    f_pend = 1'b0; d_pend = 1'b0; f_ackd = 1'b0; d_ackd = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (f_ackd) begin
        if_req = 1'b0; f_pend = 1'b0; f_ackd = 1'b0;
      end else if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1; if_req = 1'b1; if_addr = $urandom;
      end
      if (d_ackd) begin
        d_req = 1'b0; d_pend = 1'b0; d_ackd = 1'b0;
      end else if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 65535)); d_wdata = $urandom;
      end
      @(negedge clk);
      exp_en  = (cyc == en_at);
      exp_ack = (cyc == ack_at);
      if (exp_ack) begin
        if (!own_d) e_if = mem_val(own_addr);
        else if (!own_we) e_d = mem_val(own_addr);
      end
      chk("rnd_m_en", m_en1, exp_en);
      chk("rnd_m_we", m_we1, exp_en && own_d && own_we);
      if (exp_en) chk("rnd_m_addr", m_addr1, own_addr);
      if (exp_en && own_d && own_we) chk("rnd_m_wdata", m_wdata1, own_wdata);
      chk("rnd_if_ack", if_ack1, exp_ack && !own_d);
      chk("rnd_d_ack", d_ack1, exp_ack && own_d);
      chk("rnd_busy", busy1, (cyc >= en_at) && (cyc <= ack_at));
      chk("rnd_if_rdata", if_rdata1, e_if);
      chk("rnd_d_rdata", d_rdata1, e_d);
      if (if_ack1) f_ackd = 1'b1;
      if (d_ack1) d_ackd = 1'b1;
      if (cyc >= free_at) begin
        if (d_req && (!if_req || streak < MAXS)) begin
          own_d = 1'b1; own_we = d_we; own_addr = d_addr; own_wdata = d_wdata;
          streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
          en_at = cyc + 1; ack_at = cyc + 2 + LAT1; free_at = cyc + 3 + LAT1;
        end else if (if_req) begin
          own_d = 1'b0; own_we = 1'b0; own_addr = if_addr[15:0];
          streak = 0;
          en_at = cyc + 1; ack_at = cyc + 2 + LAT1; free_at = cyc + 3 + LAT1;
        end else begin
          streak = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    if_req = 1'b0; d_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles (range 1..4).
REQ-004 Parameter MAX_D_STREAK, default 2, consecutive data grants allowed while fetch waits.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous and active-high.
REQ-007 IF_REQ  in  1  instruction-fetch request, level, held until IF_ACK.
REQ-008 IF_ADDR  in  32  fetch word address; only bits [ADDR_W-1:0] used.
REQ-009 IF_ACK  out  1  one-cycle fetch completion pulse.
REQ-010 IF_RDATA  out  DATA_W  fetched instruction; valid when IF_ACK=1, held until next IF_ACK.
REQ-011 D_REQ  in  1  data-port request, level, held until D_ACK.
REQ-012 D_WE  in  1  1 = store, 0 = load.
REQ-013 D_ADDR  in  ADDR_W  data word address.
REQ-014 D_WDATA  in  DATA_W  store data.
REQ-015 D_ACK  out  1  one-cycle data completion pulse.
REQ-016 D_RDATA  out  DATA_W  load result; valid when D_ACK=1 for loads, held until next load D_ACK.
REQ-017 M_EN  out  1  shared memory port enable.
REQ-018 M_WE  out  1  shared memory write enable.
REQ-019 M_ADDR  out  ADDR_W  shared memory address.
REQ-020 M_WDATA  out  DATA_W  shared memory write data.
REQ-021 M_RDATA  in  DATA_W  memory read data, valid MEM_LAT cycles after M_EN.
REQ-022 BUSY  out  1  high whenever FSM is not IDLE.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, DONE; one transaction in flight at most.
REQ-024 IDLE: no request -> stay; else grant and latch owner, address, WE, WDATA; -> ISSUE.
REQ-025 Grant rule: data wins iff D_REQ && (!IF_REQ || streak < MAX_D_STREAK); else fetch wins if IF_REQ.
REQ-026 streak: saturating counter, +1 on data grant, cleared on fetch grant and on IF_REQ=0 in IDLE.
REQ-027 ISSUE (1 cycle): M_EN=1, M_ADDR/M_WDATA from latched values, M_WE=1 only for data store; -> WAIT.
REQ-028 WAIT: MEM_LAT-1 cycles after ISSUE (0 when MEM_LAT=1), then capture M_RDATA into owner's RDATA register (loads and fetches only); -> DONE.
REQ-029 DONE (1 cycle): owner's ACK=1; requests ignored; -> IDLE.
REQ-030 Latency with MEM_LAT=1: request sampled in IDLE at cycle 0, M_EN in cycle 1, ACK in cycle 3; total 2+MEM_LAT cycles; throughput one transaction per 2+MEM_LAT+1 cycles.
REQ-031 Stores: ACK with same timing as loads; D_RDATA unchanged.
REQ-032 M_EN, M_WE low in all states except ISSUE; M_ADDR/M_WDATA hold last values outside ISSUE.
REQ-033 Fetch path never drives M_WE=1.
REQ-034 Requester dropping REQ before ACK: latched transaction still completes and ACKs.
REQ-035 Requester must deassert REQ the cycle after ACK; REQ still high in next IDLE is a new request.
REQ-036 IF_ADDR bits above ADDR_W ignored, no error.

Reset
REQ-037 RST=1 on a rising edge: FSM -> IDLE, streak=0, all outputs 0 (ACKs, RDATA, M_* , BUSY).
REQ-038 Reset mid-transaction abandons it with no ACK; M_EN/M_WE low from the cycle after the reset edge.
REQ-039 RST has priority over all other inputs.

Structure
REQ-040 Shared package mem_arb_pkg holds state encoding and ADDR_W/DATA_W/MEM_LAT defaults.
REQ-041 One sub-module mem_arb_lat_cnt: down-counter timing the WAIT state from MEM_LAT.
REQ-042 Estimated size 150-250 lines RTL.

Verification
REQ-043 Single fetch IF_ADDR=0x10, M_RDATA=0xDEADBEEF -> M_EN cycle 1, IF_ACK cycle 3, IF_RDATA=0xDEADBEEF.
REQ-044 Store D_ADDR=0x0042, D_WDATA=0x12345678 -> M_WE=1 only in ISSUE, D_ACK cycle 3, D_RDATA unchanged.
REQ-045 IF_REQ and D_REQ held high continuously -> grant order D,D,F,D,D,F (MAX_D_STREAK=2).
REQ-046 RST asserted in WAIT -> no ACK, all outputs 0, next request served normally with full latency.
REQ-047 MEM_LAT=3 load -> ACK at cycle 5, data sampled 3 cycles after M_EN.
REQ-048 D_REQ dropped in ISSUE -> D_ACK still issued in DONE; no second memory access.
